// File: rtl/pattern_tx.sv
// Purpose : serial burst transmitter; each frame is a 4-bit preamble (MSB first) then a DATA_W payload (MSB first), repeated rpt+1 times with one idle gap between frames.
// Latency : first frame bit appears on X in the cycle after the edge that accepts start; done pulses in the cycle after the last payload bit.
// Backpres: none; start is taken only in IDLE, is otherwise dropped without queuing, and abort cancels a burst at the next edge.
//
// Ports:
//   clk    system clock, rising-edge active
//   rst    asynchronous active-high reset
//   start  burst request, sampled in IDLE only
//   abort  synchronous cancel of the current burst (wins over start)
//   data   payload, captured on an accepted start
//   rpt    extra repetitions, captured on an accepted start
//   X      registered serial bit stream
//   valid  registered, high while X carries a preamble or payload bit
//   busy   registered, high from first frame bit through last frame bit
//   done   registered one-cycle pulse after a burst completes normally
module pattern_tx #(
  parameter int          DATA_W   = 8,
  parameter logic [3:0]  PREAMBLE = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        rpt,
  output logic              X,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Bit counter is wide enough for DATA_W up to 32 and for the 4 preamble bits.
  localparam logic [5:0] DW = 6'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] sreg;   // payload shift register, MSB goes out next
  logic [DATA_W-1:0] cap;    // captured payload, reloaded for each repetition
  logic [3:0]        rcnt;   // repetitions still to send after the current frame
  logic [5:0]        bcnt;   // number of bits of the current section already on X

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cap   <= '0;
      rcnt  <= '0;
      bcnt  <= '0;
      X     <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel from any state; in IDLE this also blocks a simultaneous start.
        state <= IDLE;
        bcnt  <= '0;
        X     <= 1'b0;
        valid <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            X     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            if (start) begin
              cap   <= data;
              sreg  <= data;
              rcnt  <= rpt;
              state <= PRE;
              bcnt  <= 6'd1;
              X     <= PREAMBLE[3];
              valid <= 1'b1;
              busy  <= 1'b1;
            end
          end
          PRE: begin
            valid <= 1'b1;
            busy  <= 1'b1;
            if (bcnt < 6'd4) begin
              X    <= PREAMBLE[2'd3 - bcnt[1:0]];
              bcnt <= bcnt + 6'd1;
            end else begin
              state <= DATA;
              X     <= sreg[DATA_W-1];
              sreg  <= sreg << 1;
              bcnt  <= 6'd1;
            end
          end
          DATA: begin
            if (bcnt < DW) begin
              X     <= sreg[DATA_W-1];
              sreg  <= sreg << 1;
              bcnt  <= bcnt + 6'd1;
              valid <= 1'b1;
              busy  <= 1'b1;
            end else if (rcnt != 4'd0) begin
              rcnt  <= rcnt - 4'd1;
              sreg  <= cap;
              bcnt  <= '0;
              state <= GAP;
              X     <= 1'b0;
              valid <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              bcnt  <= '0;
              X     <= 1'b0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          GAP: begin
            state <= PRE;
            bcnt  <= 6'd1;
            X     <= PREAMBLE[3];
            valid <= 1'b1;
            busy  <= 1'b1;
          end
          default: begin
            state <= IDLE;
            bcnt  <= '0;
            X     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Purpose : self-checking bench for pattern_tx; expected {X,valid,busy,done} per cycle is queued at stimulus time and popped as cycles elapse.
// Latency : outputs sampled on the falling edge, half a cycle after the active edge.
// Backpres: n/a; inputs are driven on the falling edge with blocking assignments.
module tb_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] data;
  logic [3:0] rpt;
  logic       X;
  logic       valid;
  logic       busy;
  logic       done;

  pattern_tx #(.DATA_W(8), .PREAMBLE(4'b1011)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .data  (data),
    .rpt   (rpt),
    .X     (X),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_q[$];   // {X, valid, busy, done}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // Expected cycles of one burst, starting with the cycle after the accepting edge.
  function automatic void push_burst(input logic [7:0] d, input int r, input int tail);
    logic [3:0] pre;
    pre = 4'b1011;
    for (int f = 0; f <= r; f++) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back({pre[i], 1'b1, 1'b1, 1'b0});
      for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b1, 1'b0});
      if (f < r) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    for (int i = 0; i < tail; i++) exp_q.push_back(4'b0000);
  endfunction

  // Simple overlapping 1011 Mealy detector on the X stream.
  logic [1:0] det_st;
  int         det_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      det_st <= 2'd0;
    end else begin
      case (det_st)
        2'd0: det_st <= X ? 2'd1 : 2'd0;
        2'd1: det_st <= X ? 2'd1 : 2'd2;
        2'd2: det_st <= X ? 2'd3 : 2'd0;
        default: begin
          if (X) det_cnt <= det_cnt + 1;
          det_st <= X ? 2'd1 : 2'd2;
        end
      endcase
    end
  end

  task automatic send(input logic [7:0] d, input logic [3:0] r);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    rpt   = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Compare one queued entry per cycle. kind 1: stray start with new data,
  // kind 2: abort, kind 3: back-to-back start with data 8'h3C.
  task automatic drain(input string tag, input int poke_at, input int kind);
    int         idx;
    logic [3:0] e;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, idx), 32'({X, valid, busy, done}), 32'(e));
      if (idx == poke_at) begin
        case (kind)
          1: begin data = 8'hFF; rpt = 4'd3; start = 1'b1; end
          2: abort = 1'b1;
          3: begin data = 8'h3C; rpt = 4'd0; start = 1'b1; end
          default: ;
        endcase
      end else if (idx == poke_at + 1) begin
        start = 1'b0;
        abort = 1'b0;
      end
      idx++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; data = 8'h00; rpt = 4'd0;
    det_cnt = 0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'({X, valid, busy, done}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_out", 32'({X, valid, busy, done}), 32'h0);

    // Single frame A5.
    push_burst(8'hA5, 0, 2);
    send(8'hA5, 4'd0);
    drain("a5", -10, 0);

    // Two frames of 0F with one gap.
    push_burst(8'h0F, 1, 2);
    send(8'h0F, 4'd1);
    drain("0f_r1", -10, 0);

    // New data and start during DATA are ignored.
    push_burst(8'hA5, 0, 3);
    send(8'hA5, 4'd0);
    drain("ignore", 6, 1);

    // Abort on third payload bit: clean idle, no done.
    push_burst(8'hA5, 0, 0);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b0000);
    send(8'hA5, 4'd0);
    drain("abort", 6, 2);

    // Start and abort together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; data = 8'hA5; rpt = 4'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b0000);
    drain("st_ab", -10, 0);

    // Back-to-back: start while done is high.
    push_burst(8'h96, 0, 0);
    push_burst(8'h3C, 0, 2);
    send(8'h96, 4'd0);
    drain("b2b", 12, 3);

    // Async reset mid-preamble, then a clean 3C burst.
    push_burst(8'hA5, 0, 0);
    send(8'hA5, 4'd0);
    check("rst_pre0", 32'({X, valid, busy, done}), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("rst_pre1", 32'({X, valid, busy, done}), 32'(exp_q.pop_front()));
    exp_q.delete();
    #1 rst = 1'b1;
    #1 check("rst_async", 32'({X, valid, busy, done}), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_after", 32'({X, valid, busy, done}), 32'h0);
    push_burst(8'h3C, 0, 2);
    send(8'h3C, 4'd0);
    drain("post_rst", -10, 0);

    // Detector sees one 1011 per frame.
    det_cnt = 0;
    push_burst(8'h00, 2, 2);
    send(8'h00, 4'd2);
    drain("det", -10, 0);
    check("det_count", 32'(det_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
